mlp_chain_ctrl: RTL and testbench

MLP_CHAIN_CTRL -- requirements
Module: mlp_chain_ctrl

---
 rtl/mlp_chain_pkg.sv | 31 +++
 rtl/mlp_link.sv | 90 +++++++++
 rtl/mlp_chain_ctrl.sv | 123 ++++++++++++
 tb/tb_mlp_chain_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_chain_pkg.sv
// Shared definitions for the MLP chain controller: per-layer input buffer
// sizes, link state encoding and width helpers.
package mlp_chain_pkg;

  // Upper bound on chain length covered by the size table below.
  localparam int unsigned MAX_LAYERS = 4;

  // Input element count of each fc_layer; a chain of N layers uses the first N.
  localparam int unsigned LAYER_IN_SIZE [MAX_LAYERS] = '{4, 3, 8, 6};

  typedef enum logic [1:0] {
    LINK_FILL   = 2'd0,
    LINK_LAUNCH = 2'd1,
    LINK_RUN    = 2'd2
  } link_state_e;

  // Address width able to index the largest input buffer in the chain.
  function automatic int unsigned addr_w(input int unsigned num_layers);
    int unsigned max_sz = 2;
    for (int unsigned l = 0; l < num_layers && l < MAX_LAYERS; l++) begin
      if (LAYER_IN_SIZE[l] > max_sz) max_sz = LAYER_IN_SIZE[l];
    end
    return $clog2(max_sz);
  endfunction

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_link.sv
// One link of the chain: collects a frame from its source stream into the
// layer's input buffer, launches the layer, and waits for it to finish.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_src_valid/i_src_data       source beat (input stream or previous layer)
//   o_src_ready                  link accepts source beats (FILL state)
//   i_busy / o_start             layer handshake
//   o_ibuf_we/addr/wr_data       input buffer write port (combinational)
//   o_overflow                   source beat dropped this cycle
module mlp_link
  import mlp_chain_pkg::*;
#(
  parameter int unsigned DW      = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned IN_SIZE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_src_valid,
  input  logic [DW-1:0] i_src_data,
  output logic          o_src_ready,
  input  logic          i_busy,
  output logic          o_start,
  output logic          o_ibuf_we,
  output logic [AW-1:0] o_ibuf_addr,
  output logic [DW-1:0] o_ibuf_wr_data,
  output logic          o_overflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IN_SIZE - 1);

  link_state_e   state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          ack_q, ack_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LINK_FILL;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
    end
  end

  // Next state. ack_q records that the layer acknowledged the start by
  // raising busy, so a busy that was already low is not mistaken for done.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ack_d   = ack_q;
    unique case (state_q)
      LINK_FILL: begin
        if (i_src_valid) begin
          if (wcnt_q == LAST_ADDR) begin
            wcnt_d  = '0;
            state_d = LINK_LAUNCH;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      LINK_LAUNCH: begin
        if (!i_busy) begin
          state_d = LINK_RUN;
          ack_d   = 1'b0;
        end
      end
      LINK_RUN: begin
        if (i_busy) ack_d = 1'b1;
        else if (ack_q) state_d = LINK_FILL;
      end
      default: state_d = LINK_FILL;
    endcase
  end

  // Outputs: buffer writes track the source beat in the same cycle.
  always_comb begin
    o_src_ready    = (state_q == LINK_FILL);
    o_ibuf_we      = i_src_valid && (state_q == LINK_FILL);
    o_ibuf_addr    = wcnt_q;
    o_ibuf_wr_data = i_src_data;
    o_start        = (state_q == LINK_LAUNCH) && !i_busy;
    o_overflow     = i_src_valid && (state_q != LINK_FILL);
  end

endmodule

// File: rtl/mlp_chain_ctrl.sv
// Controller for a chain of fc_layer instances: one link per layer moves
// frames from the input stream / previous layer into each layer's input
// buffer; the final layer's output is passed through with frame framing.
// Ports:
//   clk, rst                          clock, async active-high reset
//   i_in_valid/i_in_data/o_in_ready   frame input stream into layer 0
//   o_ibuf_*, o_start, i_busy         per-layer buffer write and launch
//   i_out_valid/i_out_data            per-layer output streams
//   o_next_busy                       per-layer output backpressure
//   o_out_valid/data/last, i_out_ready  final output stream
//   o_frame_done                      pulse after last beat of a frame
//   o_overflow_err                    sticky dropped-beat flag
module mlp_chain_ctrl
  import mlp_chain_pkg::*;
#(
  parameter  int unsigned NUM_LAYERS    = 4,
  parameter  int unsigned datatype_size = 4,
  parameter  int unsigned OUT_SIZE      = 10,
  localparam int unsigned ADDR_W        = addr_w(NUM_LAYERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_valid,
  input  logic [datatype_size-1:0] i_in_data,
  output logic                     o_in_ready,
  output logic                     o_ibuf_we      [NUM_LAYERS],
  output logic [ADDR_W-1:0]        o_ibuf_addr    [NUM_LAYERS],
  output logic [datatype_size-1:0] o_ibuf_wr_data [NUM_LAYERS],
  output logic                     o_start        [NUM_LAYERS],
  input  logic                     i_busy         [NUM_LAYERS],
  input  logic                     i_out_valid    [NUM_LAYERS],
  input  logic [datatype_size-1:0] i_out_data     [NUM_LAYERS],
  output logic                     o_next_busy    [NUM_LAYERS],
  output logic                     o_out_valid,
  output logic [datatype_size-1:0] o_out_data,
  output logic                     o_out_last,
  output logic                     o_frame_done,
  output logic                     o_overflow_err,
  input  logic                     i_out_ready
);

  localparam int unsigned      OCNT_W   = cnt_w(OUT_SIZE);
  localparam logic [OCNT_W-1:0] LAST_OUT = OCNT_W'(OUT_SIZE - 1);

  logic                     src_valid  [NUM_LAYERS];
  logic [datatype_size-1:0] src_data   [NUM_LAYERS];
  logic                     link_ready [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]    link_ovf;

  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              out_beat;

  // One link per layer; link l is fed by layer l-1 and backpressures it.
  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_link
    if (l == 0) begin : g_first
      assign src_valid[l] = i_in_valid;
      assign src_data[l]  = i_in_data;
      assign o_in_ready   = link_ready[l];
    end else begin : g_inner
      assign src_valid[l]     = i_out_valid[l-1];
      assign src_data[l]      = i_out_data[l-1];
      assign o_next_busy[l-1] = !link_ready[l];
    end

    mlp_link #(
      .DW      (datatype_size),
      .AW      (ADDR_W),
      .IN_SIZE (LAYER_IN_SIZE[l])
    ) u_link (
      .clk            (clk),
      .rst            (rst),
      .i_src_valid    (src_valid[l]),
      .i_src_data     (src_data[l]),
      .o_src_ready    (link_ready[l]),
      .i_busy         (i_busy[l]),
      .o_start        (o_start[l]),
      .o_ibuf_we      (o_ibuf_we[l]),
      .o_ibuf_addr    (o_ibuf_addr[l]),
      .o_ibuf_wr_data (o_ibuf_wr_data[l]),
      .o_overflow     (link_ovf[l])
    );
  end

  // Final layer output passes straight through to the downstream consumer.
  assign o_next_busy[NUM_LAYERS-1] = !i_out_ready;
  assign o_out_valid = i_out_valid[NUM_LAYERS-1];
  assign o_out_data  = i_out_data[NUM_LAYERS-1];
  assign out_beat    = i_out_valid[NUM_LAYERS-1] && i_out_ready;
  assign o_out_last  = (ocnt_q == LAST_OUT);

  // Output beat counter, frame-done pulse and sticky overflow.
  always_comb begin
    ocnt_d       = ocnt_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (|link_ovf);
    if (out_beat) begin
      if (ocnt_q == LAST_OUT) begin
        ocnt_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        ocnt_d = ocnt_q + OCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocnt_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      ocnt_q       <= ocnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_frame_done   = frame_done_q;
  assign o_overflow_err = overflow_q;

endmodule

// File: tb/tb_mlp_chain_ctrl.sv
// Bench for mlp_chain_ctrl with a two-layer chain (input sizes 4 and 3,
// two output beats per frame). Inputs change on the falling edge; outputs
// are sampled 1 time unit later, well before the next rising edge.
module tb_mlp_chain_ctrl;
  import mlp_chain_pkg::*;

  localparam int unsigned NL  = 2;
  localparam int unsigned DW  = 4;
  localparam int unsigned OS  = 2;
  localparam int unsigned AW  = addr_w(NL);
  localparam int unsigned IN0 = 4;
  localparam int unsigned IN1 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_valid;
  logic [DW-1:0] i_in_data;
  logic          o_in_ready;
  logic          o_ibuf_we      [NL];
  logic [AW-1:0] o_ibuf_addr    [NL];
  logic [DW-1:0] o_ibuf_wr_data [NL];
  logic          o_start        [NL];
  logic          i_busy         [NL];
  logic          i_out_valid    [NL];
  logic [DW-1:0] i_out_data     [NL];
  logic          o_next_busy    [NL];
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;
  logic          o_frame_done;
  logic          o_overflow_err;
  logic          i_out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mlp_chain_ctrl #(.NUM_LAYERS(NL), .datatype_size(DW), .OUT_SIZE(OS)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_ibuf_we(o_ibuf_we), .o_ibuf_addr(o_ibuf_addr), .o_ibuf_wr_data(o_ibuf_wr_data),
    .o_start(o_start), .i_busy(i_busy),
    .i_out_valid(i_out_valid), .i_out_data(i_out_data), .o_next_busy(o_next_busy),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_frame_done(o_frame_done), .o_overflow_err(o_overflow_err), .i_out_ready(i_out_ready)
  );

  task automatic idle_inputs();
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b1;
    for (int l = 0; l < int'(NL); l++) begin
      i_busy[l] = 1'b0; i_out_valid[l] = 1'b0; i_out_data[l] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_start[0] !== 1'b0 || o_start[1] !== 1'b0) begin failures++; $display("FAIL reset_start got=%b%b exp=00", o_start[1], o_start[0]); end
    checks++; if (o_ibuf_we[0] !== 1'b0 || o_ibuf_we[1] !== 1'b0) begin failures++; $display("FAIL reset_ibuf_we got=%b%b exp=00", o_ibuf_we[1], o_ibuf_we[0]); end
    checks++; if (o_frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
    checks++; if (o_overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", o_overflow_err); end
    checks++; if (o_next_busy[0] !== 1'b0) begin failures++; $display("FAIL reset_next_busy0 got=%b exp=0", o_next_busy[0]); end
    checks++; if (o_out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", o_out_last); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Four back-to-back beats fill layer 0, then launch and busy handshake.
  task automatic test_fill_launch();
    do_reset();
    for (int k = 0; k < int'(IN0); k++) begin
      i_in_valid = 1'b1; i_in_data = DW'(k + 1); #1;
      checks++; if (o_ibuf_we[0] !== 1'b1) begin failures++; $display("FAIL fill_we beat=%0d got=%b exp=1", k, o_ibuf_we[0]); end
      checks++; if (o_ibuf_addr[0] !== AW'(k)) begin failures++; $display("FAIL fill_addr beat=%0d got=%0d exp=%0d", k, o_ibuf_addr[0], k); end
      checks++; if (o_ibuf_wr_data[0] !== DW'(k + 1)) begin failures++; $display("FAIL fill_data beat=%0d got=%0d exp=%0d", k, o_ibuf_wr_data[0], k + 1); end
      checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL fill_early_start beat=%0d got=%b exp=0", k, o_start[0]); end
      @(negedge clk);
    end
    i_in_valid = 1'b0; #1;
    checks++; if (o_start[0] !== 1'b1) begin failures++; $display("FAIL launch_start got=%b exp=1", o_start[0]); end
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL launch_ready got=%b exp=0", o_in_ready); end
    @(negedge clk); #1;
    checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL launch_start_width got=%b exp=0", o_start[0]); end
    for (int c = 0; c < 2; c++) begin
      i_busy[0] = 1'b1; #1;
      checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL run_busy_ready cyc=%0d got=%b exp=0", c, o_in_ready); end
      @(negedge clk);
    end
    i_busy[0] = 1'b0; #1;
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL run_fall_ready got=%b exp=0", o_in_ready); end
    @(negedge clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL run_done_ready got=%b exp=1", o_in_ready); end
  endtask

  // Launch held off by busy for 5 cycles; busy pulse of one cycle completes.
  task automatic test_launch_delay();
    do_reset();
    i_busy[0] = 1'b1;
    for (int k = 0; k < int'(IN0); k++) begin
      i_in_valid = 1'b1; i_in_data = DW'(k + 8);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL delay_start_while_busy cyc=%0d got=%b exp=0", c, o_start[0]); end
      @(negedge clk);
    end
    i_busy[0] = 1'b0; #1;
    checks++; if (o_start[0] !== 1'b1) begin failures++; $display("FAIL delay_start got=%b exp=1", o_start[0]); end
    @(negedge clk); #1;
    checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL delay_start_width got=%b exp=0", o_start[0]); end
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL delay_run_ready got=%b exp=0", o_in_ready); end
    @(negedge clk);
    i_busy[0] = 1'b1; @(negedge clk);
    i_busy[0] = 1'b0; #1;
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL pulse_fall_ready got=%b exp=0", o_in_ready); end
    @(negedge clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL pulse_done_ready got=%b exp=1", o_in_ready); end
  endtask

  // Layer 0 output into link 1 while link 1 is running: dropped, flagged.
  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < int'(IN1); k++) begin
      i_out_valid[0] = 1'b1; i_out_data[0] = DW'(k + 5); #1;
      checks++; if (o_ibuf_we[1] !== 1'b1 || o_ibuf_addr[1] !== AW'(k) || o_ibuf_wr_data[1] !== DW'(k + 5))
        begin failures++; $display("FAIL bp_fill1 beat=%0d got we=%b addr=%0d data=%0d exp we=1 addr=%0d data=%0d", k, o_ibuf_we[1], o_ibuf_addr[1], o_ibuf_wr_data[1], k, k + 5); end
      checks++; if (o_next_busy[0] !== 1'b0) begin failures++; $display("FAIL bp_fill_next_busy beat=%0d got=%b exp=0", k, o_next_busy[0]); end
      @(negedge clk);
    end
    i_out_valid[0] = 1'b0; #1;
    checks++; if (o_start[1] !== 1'b1) begin failures++; $display("FAIL bp_start1 got=%b exp=1", o_start[1]); end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      i_out_valid[0] = 1'b1; i_out_data[0] = DW'(k); #1;
      checks++; if (o_next_busy[0] !== 1'b1) begin failures++; $display("FAIL bp_next_busy beat=%0d got=%b exp=1", k, o_next_busy[0]); end
      checks++; if (o_ibuf_we[1] !== 1'b0) begin failures++; $display("FAIL bp_dropped_we beat=%0d got=%b exp=0", k, o_ibuf_we[1]); end
      if (k == 0) begin
        checks++; if (o_overflow_err !== 1'b0) begin failures++; $display("FAIL bp_overflow_early got=%b exp=0", o_overflow_err); end
      end
      @(negedge clk);
    end
    i_out_valid[0] = 1'b0; #1;
    checks++; if (o_overflow_err !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", o_overflow_err); end
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bp_link0_ready got=%b exp=1", o_in_ready); end
    i_busy[1] = 1'b1; @(negedge clk);
    i_busy[1] = 1'b0; @(negedge clk);
    i_out_valid[0] = 1'b1; i_out_data[0] = DW'(7); #1;
    checks++; if (o_ibuf_we[1] !== 1'b1 || o_ibuf_addr[1] !== AW'(0))
      begin failures++; $display("FAIL bp_refill_addr got we=%b addr=%0d exp we=1 addr=0", o_ibuf_we[1], o_ibuf_addr[1]); end
    @(negedge clk);
    i_out_valid[0] = 1'b0; #1;
    checks++; if (o_overflow_err !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", o_overflow_err); end
  endtask

  // Final output framing with a stalled beat in the middle.
  task automatic test_output_frame();
    do_reset();
    i_out_valid[1] = 1'b1; i_out_data[1] = 4'hA; i_out_ready = 1'b1; #1;
    checks++; if (o_out_valid !== 1'b1 || o_out_data !== 4'hA) begin failures++; $display("FAIL out_pass got v=%b d=%h exp v=1 d=a", o_out_valid, o_out_data); end
    checks++; if (o_out_last !== 1'b0) begin failures++; $display("FAIL out_last_first got=%b exp=0", o_out_last); end
    checks++; if (o_next_busy[1] !== 1'b0) begin failures++; $display("FAIL out_next_busy_rdy got=%b exp=0", o_next_busy[1]); end
    @(negedge clk);
    i_out_data[1] = 4'hB; i_out_ready = 1'b0; #1;
    checks++; if (o_next_busy[1] !== 1'b1) begin failures++; $display("FAIL out_next_busy_stall got=%b exp=1", o_next_busy[1]); end
    checks++; if (o_out_last !== 1'b1) begin failures++; $display("FAIL out_last_stall got=%b exp=1", o_out_last); end
    checks++; if (o_frame_done !== 1'b0) begin failures++; $display("FAIL out_done_early got=%b exp=0", o_frame_done); end
    @(negedge clk);
    i_out_ready = 1'b1; #1;
    checks++; if (o_out_last !== 1'b1 || o_frame_done !== 1'b0) begin failures++; $display("FAIL out_last_second got last=%b done=%b exp last=1 done=0", o_out_last, o_frame_done); end
    @(negedge clk);
    i_out_valid[1] = 1'b0; #1;
    checks++; if (o_frame_done !== 1'b1) begin failures++; $display("FAIL out_frame_done got=%b exp=1", o_frame_done); end
    checks++; if (o_out_last !== 1'b0) begin failures++; $display("FAIL out_last_wrap got=%b exp=0", o_out_last); end
    @(negedge clk); #1;
    checks++; if (o_frame_done !== 1'b0) begin failures++; $display("FAIL out_done_width got=%b exp=0", o_frame_done); end
  endtask

  // Reset after two beats discards the partial frame.
  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_in_valid = 1'b1; i_in_data = DW'(k + 1);
      @(negedge clk);
    end
    i_in_valid = 1'b0; rst = 1'b1; #1;
    checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL mid_start_in_rst got=%b exp=0", o_start[0]); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (o_overflow_err !== 1'b0 || o_in_ready !== 1'b1) begin failures++; $display("FAIL mid_post_rst got ovf=%b rdy=%b exp ovf=0 rdy=1", o_overflow_err, o_in_ready); end
    for (int k = 0; k < int'(IN0); k++) begin
      i_in_valid = 1'b1; i_in_data = DW'(k + 9); #1;
      checks++; if (o_ibuf_we[0] !== 1'b1 || o_ibuf_addr[0] !== AW'(k)) begin failures++; $display("FAIL mid_refill beat=%0d got we=%b addr=%0d exp we=1 addr=%0d", k, o_ibuf_we[0], o_ibuf_addr[0], k); end
      checks++; if (o_start[0] !== 1'b0) begin failures++; $display("FAIL mid_no_start beat=%0d got=%b exp=0", k, o_start[0]); end
      @(negedge clk);
    end
    i_in_valid = 1'b0; #1;
    checks++; if (o_start[0] !== 1'b1) begin failures++; $display("FAIL mid_start_full got=%b exp=1", o_start[0]); end
    @(negedge clk);
  endtask

  // Random traffic on link 0 and the final output against a frame-level model.
  task automatic test_random();
    int          phase;   // 0 collecting, 1 waiting to launch, 2 layer computing
    int unsigned nbeats;
    bit          ack, ovf, fd, v, b, ov, rd, exp_ready;
    int unsigned ocnt;
    logic [DW-1:0] d, od;
    do_reset();
    phase = 0; nbeats = 0; ack = 0; ovf = 0; fd = 0; ocnt = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      checks++; if (o_overflow_err !== ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, o_overflow_err, ovf); end
      checks++; if (o_frame_done !== fd) begin failures++; $display("FAIL rnd_frame_done cyc=%0d got=%b exp=%b", c, o_frame_done, fd); end
      exp_ready = (phase == 0);
      v  = exp_ready ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 2) == 0);
      d  = DW'($urandom);
      ov = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 6);
      od = DW'($urandom);
      i_in_valid = v; i_in_data = d; i_busy[0] = b;
      i_out_valid[1] = ov; i_out_data[1] = od; i_out_ready = rd;
      #1;
      checks++; if (o_in_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, o_in_ready, exp_ready); end
      checks++; if (o_start[0] !== (phase == 1 && !b)) begin failures++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", c, o_start[0], (phase == 1 && !b)); end
      checks++; if (o_ibuf_we[0] !== (v && exp_ready)) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, o_ibuf_we[0], (v && exp_ready)); end
      if (v && exp_ready) begin
        checks++; if (o_ibuf_addr[0] !== AW'(nbeats) || o_ibuf_wr_data[0] !== d)
          begin failures++; $display("FAIL rnd_write cyc=%0d got addr=%0d data=%0d exp addr=%0d data=%0d", c, o_ibuf_addr[0], o_ibuf_wr_data[0], nbeats, d); end
      end
      checks++; if (o_out_last !== (ocnt == OS - 1)) begin failures++; $display("FAIL rnd_last cyc=%0d got=%b exp=%b", c, o_out_last, (ocnt == OS - 1)); end
      checks++; if (o_out_valid !== ov || o_out_data !== od || o_next_busy[1] !== !rd)
        begin failures++; $display("FAIL rnd_out_pass cyc=%0d got v=%b d=%0d nb=%b exp v=%b d=%0d nb=%b", c, o_out_valid, o_out_data, o_next_busy[1], ov, od, !rd); end
      fd = ov && rd && (ocnt == OS - 1);
      if (ov && rd) ocnt = (ocnt + 1) % OS;
      if (v && !exp_ready) ovf = 1'b1;
      case (phase)
        0: if (v) begin
             nbeats++;
             if (nbeats == IN0) begin nbeats = 0; phase = 1; end
           end
        1: if (!b) begin phase = 2; ack = 1'b0; end
        default: begin
          if (b) ack = 1'b1;
          else if (ack) phase = 0;
        end
      endcase
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill_launch();
    test_launch_delay();
    test_backpressure();
    test_output_frame();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
